user_irq_ctrl: RTL and testbench

//  External interrupt front-end for the management core. Sits directly upstream
//  of the mgmt core IRQ input and feeds it.

---
 rtl/user_irq_ctrl_if.sv | 21 ++
 rtl/user_irq_ctrl.sv | 132 +++++++++++++
 tb/tb_user_irq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/user_irq_ctrl_if.sv
// Wishbone classic slave bus bundle for the external interrupt front-end.
interface user_irq_ctrl_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [1:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/user_irq_ctrl.sv
// External interrupt front-end for the management core: synchronises pad IRQ
// lines, detects level/edge per line, latches PENDING, masks with ENABLE and
// drives a registered irq_o. Registers are serviced over classic Wishbone.
module user_irq_ctrl #(
   parameter int NUM_IRQ     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               core_clk,
   input  logic               core_rstn,
   input  logic [NUM_IRQ-1:0] irq_in,
   user_irq_ctrl_if.slave     wb,
   output logic               irq_o
);

   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] hist_q;
   logic [NUM_IRQ-1:0] pend_q;
   logic [NUM_IRQ-1:0] en_q;
   logic [NUM_IRQ-1:0] mode_q;
   logic [NUM_IRQ-1:0] pol_q;
   logic               ack_q;
   logic [31:0]        dat_q;
   logic               irq_q;

   logic [NUM_IRQ-1:0] sync_s;
   logic [NUM_IRQ-1:0] wmask;
   logic [NUM_IRQ-1:0] wdat;
   logic [NUM_IRQ-1:0] w1c;
   logic [NUM_IRQ-1:0] evt_edge;
   logic [NUM_IRQ-1:0] evt_lvl;
   logic [NUM_IRQ-1:0] pend_d;
   logic [31:0]        rd_val;
   logic               req;
   logic               wr;
   logic               unused_bus;

   // Byte-lane write: only lanes with wb_sel_i set take new data.
   function automatic logic [NUM_IRQ-1:0] merge(input logic [NUM_IRQ-1:0] old_v,
                                                input logic [NUM_IRQ-1:0] new_v,
                                                input logic [NUM_IRQ-1:0] m);
      return (old_v & ~m) | (new_v & m);
   endfunction

   // A new request is accepted only when no ack is outstanding, so ack never
   // stays high for two consecutive cycles under a held strobe.
   assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
   assign wr     = req & wb.wb_we_i;
   assign wdat   = wb.wb_dat_i[NUM_IRQ-1:0];
   assign sync_s = sync_q[SYNC_STAGES-1];

   // Data bits above NUM_IRQ and unused byte lanes are ignored by design.
   assign unused_bus = &{1'b0, wb.wb_dat_i, wb.wb_sel_i};

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_mask
      assign wmask[g] = wb.wb_sel_i[g/8];
   end

   // Detection and next PENDING value; edges use the raw synchronised
   // history so rewriting POL can never fabricate an edge.
   always_comb begin
      w1c      = '0;
      if (wr && (wb.wb_adr_i == 2'd0)) w1c = wdat & wmask;
      evt_edge = (pol_q & hist_q & ~sync_s) | (~pol_q & sync_s & ~hist_q);
      evt_lvl  = sync_s ^ pol_q;
      pend_d   = (mode_q & ((pend_q & ~w1c) | evt_edge)) | (~mode_q & evt_lvl);
   end

   // Register read mux; bits at and above NUM_IRQ read as zero.
   always_comb begin
      rd_val = '0;
      case (wb.wb_adr_i)
         2'd0:    rd_val[NUM_IRQ-1:0] = pend_q;
         2'd1:    rd_val[NUM_IRQ-1:0] = en_q;
         2'd2:    rd_val[NUM_IRQ-1:0] = mode_q;
         default: rd_val[NUM_IRQ-1:0] = pol_q;
      endcase
   end

   // Synchroniser chain plus one-cycle history of its output.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         hist_q <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         hist_q <= sync_s;
      end
   end

   // PENDING update every cycle, configuration writes on the accepting edge.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         pend_q <= '0;
         en_q   <= '0;
         mode_q <= '0;
         pol_q  <= '0;
      end else begin
         pend_q <= pend_d;
         if (wr) begin
            case (wb.wb_adr_i)
               2'd1:    en_q   <= merge(en_q, wdat, wmask);
               2'd2:    mode_q <= merge(mode_q, wdat, wmask);
               2'd3:    pol_q  <= merge(pol_q, wdat, wmask);
               default: ;
            endcase
         end
      end
   end

   // Single-cycle ack with read data valid only while ack is high.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= req;
         dat_q <= req ? rd_val : 32'd0;
      end
   end

   // Registered interrupt request, one cycle behind PENDING & ENABLE.
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) irq_q <= 1'b0;
      else            irq_q <= |(pend_q & en_q);
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_user_irq_ctrl.sv
// Self-checking bench for user_irq_ctrl: directed scenarios plus randomized
// bus/IRQ traffic, compared every cycle against a rule-level reference model.
module tb_user_irq_ctrl;
   localparam int N  = 4;
   localparam int SS = 2;

   logic          core_clk  = 1'b0;
   logic          core_rstn = 1'b1;
   logic [N-1:0]  irq_in    = '0;
   logic          irq_o;
   logic [N-1:0]  cur_irq   = '0;

   user_irq_ctrl_if wb_if ();

   user_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(SS)) dut (
      .core_clk  (core_clk),
      .core_rstn (core_rstn),
      .irq_in    (irq_in),
      .wb        (wb_if),
      .irq_o     (irq_o)
   );

   always #5 core_clk = ~core_clk;

   int err_cnt = 0;
   int chk_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   logic [N-1:0] m_pend, m_en, m_mode, m_pol;
   logic         m_ack, m_irq;
   logic [31:0]  m_dat;
   logic [N-1:0] hist[$];

   task automatic model_reset();
      m_pend = '0; m_en = '0; m_mode = '0; m_pol = '0;
      m_ack = 1'b0; m_irq = 1'b0; m_dat = '0;
      hist = {};
      repeat (SS + 1) hist.push_back('0);
   endtask

   // One clock edge of the model, from the inputs present before the edge.
   task automatic model_step();
      logic         req, wr, s, h, evt, clr;
      logic [N-1:0] line_s, line_h, npend;
      logic [31:0]  rd;
      req    = wb_if.wb_cyc_i & wb_if.wb_stb_i & ~m_ack;
      wr     = req & wb_if.wb_we_i;
      line_s = hist[SS-1];
      line_h = hist[SS];
      case (wb_if.wb_adr_i)
         2'd0:    rd = {28'd0, m_pend};
         2'd1:    rd = {28'd0, m_en};
         2'd2:    rd = {28'd0, m_mode};
         default: rd = {28'd0, m_pol};
      endcase
      for (int i = 0; i < N; i++) begin
         s = line_s[i];
         h = line_h[i];
         if (m_mode[i]) evt = m_pol[i] ? (h && !s) : (s && !h);
         else           evt = s ^ m_pol[i];
         clr = wr && (wb_if.wb_adr_i == 2'd0) && wb_if.wb_sel_i[0] && wb_if.wb_dat_i[i];
         if (m_mode[i]) npend[i] = evt || (m_pend[i] && !clr);
         else           npend[i] = evt;
      end
      m_irq = |(m_pend & m_en);
      if (wr && wb_if.wb_sel_i[0]) begin
         if (wb_if.wb_adr_i == 2'd1) m_en   = wb_if.wb_dat_i[N-1:0];
         if (wb_if.wb_adr_i == 2'd2) m_mode = wb_if.wb_dat_i[N-1:0];
         if (wb_if.wb_adr_i == 2'd3) m_pol  = wb_if.wb_dat_i[N-1:0];
      end
      m_pend = npend;
      m_ack  = req;
      m_dat  = req ? rd : 32'd0;
      hist.push_front(irq_in);
      void'(hist.pop_back());
   endtask

   // Drive one cycle of inputs at the falling edge, step model on the rising
   // edge, compare outputs at the next falling edge.
   task automatic tick(input logic c, input logic we, input logic [1:0] a,
                       input logic [3:0] se, input logic [31:0] d);
      wb_if.wb_cyc_i = c;
      wb_if.wb_stb_i = c;
      wb_if.wb_we_i  = we;
      wb_if.wb_adr_i = a;
      wb_if.wb_sel_i = se;
      wb_if.wb_dat_i = d;
      irq_in         = cur_irq;
      @(posedge core_clk);
      model_step();
      @(negedge core_clk);
      check_eq("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
      check_eq("ack", {31'd0, wb_if.wb_ack_o}, {31'd0, m_ack});
      check_eq("dat_o", wb_if.wb_dat_o, m_dat);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 2'd0, 4'h0, 32'd0);
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [3:0] se, input logic [31:0] d);
      tick(1'b1, 1'b1, a, se, d);
      idle(1);
   endtask

   task automatic wb_read(input logic [1:0] a);
      tick(1'b1, 1'b0, a, 4'hF, 32'd0);
      idle(1);
   endtask

   // Reset asserted between edges while a write strobe is active.
   task automatic reset_mid_cycle();
      wb_if.wb_cyc_i = 1'b1; wb_if.wb_stb_i = 1'b1; wb_if.wb_we_i = 1'b1;
      wb_if.wb_adr_i = 2'd1; wb_if.wb_sel_i = 4'hF; wb_if.wb_dat_i = 32'hF;
      #2 core_rstn = 1'b0;
      @(posedge core_clk);
      @(negedge core_clk);
      check_eq("mid_rst_ack", {31'd0, wb_if.wb_ack_o}, 32'd0);
      check_eq("mid_rst_irq", {31'd0, irq_o}, 32'd0);
      check_eq("mid_rst_dat", wb_if.wb_dat_o, 32'd0);
      model_reset();
      wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0;
      core_rstn = 1'b1;
      wb_read(2'd1);
   endtask

   initial begin
      logic [N-1:0] flip;
      wb_if.wb_cyc_i = 1'b0; wb_if.wb_stb_i = 1'b0; wb_if.wb_we_i = 1'b0;
      wb_if.wb_adr_i = 2'd0; wb_if.wb_sel_i = 4'h0; wb_if.wb_dat_i = 32'd0;
      irq_in  = 4'hF;
      cur_irq = 4'hF;
      #1 core_rstn = 1'b0;
      repeat (3) @(negedge core_clk);
      check_eq("rst_irq", {31'd0, irq_o}, 32'd0);
      check_eq("rst_ack", {31'd0, wb_if.wb_ack_o}, 32'd0);
      check_eq("rst_dat", wb_if.wb_dat_o, 32'd0);
      model_reset();
      cur_irq   = '0;
      irq_in    = '0;
      core_rstn = 1'b1;
      for (int a = 0; a < 4; a++) wb_read(2'(a));

      // Rising edge on line 0, then W1C
      wb_write(2'd2, 4'hF, 32'h1);
      wb_write(2'd1, 4'hF, 32'h1);
      cur_irq = 4'h1; idle(3);
      cur_irq = 4'h0; idle(2);
      wb_read(2'd0);
      wb_write(2'd0, 4'hF, 32'h1);
      idle(2);
      wb_read(2'd0);

      // Edge arrives on the same edge as W1C of bit 0
      cur_irq = 4'h1; idle(2);
      tick(1'b1, 1'b1, 2'd0, 4'hF, 32'h1);
      idle(2);
      wb_read(2'd0);
      cur_irq = 4'h0; idle(2);

      // Level, active-low on line 1
      wb_write(2'd2, 4'hF, 32'h0);
      wb_write(2'd3, 4'hF, 32'h2);
      wb_write(2'd1, 4'hF, 32'h2);
      idle(4);
      wb_write(2'd0, 4'hF, 32'h2);
      wb_read(2'd0);
      cur_irq = 4'h2; idle(4);

      // Masked edge on line 3, then unmask
      wb_write(2'd1, 4'hF, 32'h0);
      wb_write(2'd3, 4'hF, 32'h0);
      wb_write(2'd2, 4'hF, 32'hF);
      wb_write(2'd0, 4'hF, 32'hF);
      cur_irq = 4'hA; idle(4);
      wb_read(2'd0);
      wb_write(2'd1, 4'hF, 32'h8);
      idle(3);

      // Held strobe, byte-select write, readback
      repeat (4) tick(1'b1, 1'b0, 2'd1, 4'hF, 32'd0);
      idle(1);
      wb_write(2'd1, 4'h1, 32'hFFFF_FFFF);
      wb_write(2'd2, 4'hE, 32'h0);
      wb_read(2'd1);
      wb_read(2'd2);

      reset_mid_cycle();

      // Randomized traffic
      for (int r = 0; r < 2500; r++) begin
         flip = '0;
         for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) flip[b] = 1'b1;
         cur_irq ^= flip;
         if ($urandom_range(9) < 3)
            tick(1'b1, 1'($urandom_range(1)), 2'($urandom_range(3)),
                 ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'hF,
                 ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(15)));
         else
            idle(1);
         if (r == 1200) reset_mid_cycle();
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
